// File: rtl/wb_commit_arbiter_if.sv
// Write-back commit bus: two result sources in, one register-file write port
// and hazard/status signals out.
interface wb_commit_arbiter_if;
    logic        exe_valid;
    logic [3:0]  exe_dest;
    logic [31:0] exe_result;
    logic        exe_ready;
    logic        mem_valid;
    logic [3:0]  mem_dest;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        writeBackEn;
    logic [3:0]  Dest_wb;
    logic [31:0] Result_WB;
    logic [14:0] pending_mask;
    logic        err_pc_write;

    modport master (
        output exe_valid, exe_dest, exe_result,
        output mem_valid, mem_dest, mem_data,
        input  exe_ready, mem_ready,
        input  writeBackEn, Dest_wb, Result_WB, pending_mask, err_pc_write
    );

    modport slave (
        input  exe_valid, exe_dest, exe_result,
        input  mem_valid, mem_dest, mem_data,
        output exe_ready, mem_ready,
        output writeBackEn, Dest_wb, Result_WB, pending_mask, err_pc_write
    );
endinterface

// File: rtl/wb_commit_arbiter.sv
// Program-order write-back arbiter for the EXE and MEM result paths.
// Optional WB_BYPASS_EN lets an offer skip its empty FIFO when it would win.
module wb_commit_arbiter #(
    parameter int DEPTH = 4,
    parameter int SEQW  = 4
) (
    input logic clk,
    input logic rst,
    wb_commit_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef logic [AW:0]     ptr_t;
    typedef logic [SEQW-1:0] tag_t;

    logic [3:0]  exe_dq [DEPTH];
    logic [31:0] exe_vq [DEPTH];
    tag_t        exe_tq [DEPTH];
    logic [3:0]  mem_dq [DEPTH];
    logic [31:0] mem_vq [DEPTH];
    tag_t        mem_tq [DEPTH];

    ptr_t exe_wr, exe_rd, mem_wr, mem_rd;
    tag_t seq;

    logic        wbe_q;
    logic [3:0]  dest_q;
    logic [31:0] result_q;
    logic        err_q;

    logic exe_empty, exe_full, mem_empty, mem_full;
    logic exe_acc, mem_acc;
    tag_t exe_tag_in, mem_tag_in;

    logic        exe_cv, mem_cv, exe_byp, mem_byp;
    logic [3:0]  exe_cd, mem_cd;
    logic [31:0] exe_cr, mem_cr;
    tag_t        exe_ct, mem_ct, age_diff;
    logic        mem_older, pick_exe, pick_mem;
    logic [3:0]  win_dest;
    logic [31:0] win_data;
    logic        exe_push, exe_pop, mem_push, mem_pop;
    logic [14:0] pend;

    function automatic logic [14:0] dest_bit(input logic [3:0] d);
        dest_bit = '0;
        if (d != 4'hF) dest_bit[d] = 1'b1;
    endfunction

    assign exe_empty = (exe_wr == exe_rd);
    assign exe_full  = (exe_wr[AW] != exe_rd[AW]) && (exe_wr[AW-1:0] == exe_rd[AW-1:0]);
    assign mem_empty = (mem_wr == mem_rd);
    assign mem_full  = (mem_wr[AW] != mem_rd[AW]) && (mem_wr[AW-1:0] == mem_rd[AW-1:0]);

    assign exe_acc = bus.exe_valid && !exe_full;
    assign mem_acc = bus.mem_valid && !mem_full;

    // MEM is the older instruction when both arrive together.
    assign mem_tag_in = seq;
    assign exe_tag_in = mem_acc ? seq + tag_t'(1) : seq;

    always_comb begin
        exe_cv  = !exe_empty;
        exe_cd  = exe_dq[exe_rd[AW-1:0]];
        exe_cr  = exe_vq[exe_rd[AW-1:0]];
        exe_ct  = exe_tq[exe_rd[AW-1:0]];
        exe_byp = 1'b0;
        mem_cv  = !mem_empty;
        mem_cd  = mem_dq[mem_rd[AW-1:0]];
        mem_cr  = mem_vq[mem_rd[AW-1:0]];
        mem_ct  = mem_tq[mem_rd[AW-1:0]];
        mem_byp = 1'b0;
`ifdef WB_BYPASS_EN
        if (exe_empty && exe_acc) begin
            exe_cv  = 1'b1;
            exe_cd  = bus.exe_dest;
            exe_cr  = bus.exe_result;
            exe_ct  = exe_tag_in;
            exe_byp = 1'b1;
        end
        if (mem_empty && mem_acc) begin
            mem_cv  = 1'b1;
            mem_cd  = bus.mem_dest;
            mem_cr  = bus.mem_data;
            mem_ct  = mem_tag_in;
            mem_byp = 1'b1;
        end
`endif
    end

    // exe_tag - mem_tag in 1..2^(SEQW-1)-1 means the MEM head is older.
    assign age_diff  = exe_ct - mem_ct;
    assign mem_older = (age_diff != '0) && !age_diff[SEQW-1];
    assign pick_mem  = mem_cv && (!exe_cv || mem_older);
    assign pick_exe  = exe_cv && !pick_mem;
    assign win_dest  = pick_mem ? mem_cd : exe_cd;
    assign win_data  = pick_mem ? mem_cr : exe_cr;

    assign exe_push = exe_acc && !(pick_exe && exe_byp);
    assign exe_pop  = pick_exe && !exe_byp;
    assign mem_push = mem_acc && !(pick_mem && mem_byp);
    assign mem_pop  = pick_mem && !mem_byp;

    always_ff @(posedge clk) begin
        if (exe_push) begin
            exe_dq[exe_wr[AW-1:0]] <= bus.exe_dest;
            exe_vq[exe_wr[AW-1:0]] <= bus.exe_result;
            exe_tq[exe_wr[AW-1:0]] <= exe_tag_in;
        end
        if (mem_push) begin
            mem_dq[mem_wr[AW-1:0]] <= bus.mem_dest;
            mem_vq[mem_wr[AW-1:0]] <= bus.mem_data;
            mem_tq[mem_wr[AW-1:0]] <= mem_tag_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exe_wr   <= '0;
            exe_rd   <= '0;
            mem_wr   <= '0;
            mem_rd   <= '0;
            seq      <= '0;
            wbe_q    <= 1'b0;
            dest_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (exe_push) exe_wr <= exe_wr + ptr_t'(1);
            if (exe_pop)  exe_rd <= exe_rd + ptr_t'(1);
            if (mem_push) mem_wr <= mem_wr + ptr_t'(1);
            if (mem_pop)  mem_rd <= mem_rd + ptr_t'(1);
            seq <= seq + tag_t'(exe_acc) + tag_t'(mem_acc);

            // PC-destined results retire silently: the register file has no R15.
            if ((pick_exe || pick_mem) && (win_dest != 4'hF)) begin
                wbe_q    <= 1'b1;
                dest_q   <= win_dest;
                result_q <= win_data;
            end else begin
                wbe_q <= 1'b0;
            end

            if ((exe_acc && bus.exe_dest == 4'hF) || (mem_acc && bus.mem_dest == 4'hF))
                err_q <= 1'b1;
        end
    end

    always_comb begin : pend_calc
        logic [AW-1:0] off;
        ptr_t          exe_occ;
        ptr_t          mem_occ;
        pend    = '0;
        exe_occ = exe_wr - exe_rd;
        mem_occ = mem_wr - mem_rd;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - exe_rd[AW-1:0];
            if ({1'b0, off} < exe_occ) pend = pend | dest_bit(exe_dq[i]);
            off = AW'(i) - mem_rd[AW-1:0];
            if ({1'b0, off} < mem_occ) pend = pend | dest_bit(mem_dq[i]);
        end
        if (wbe_q) pend = pend | dest_bit(dest_q);
    end

    assign bus.exe_ready    = !exe_full;
    assign bus.mem_ready    = !mem_full;
    assign bus.writeBackEn  = wbe_q;
    assign bus.Dest_wb      = dest_q;
    assign bus.Result_WB    = result_q;
    assign bus.pending_mask = pend;
    assign bus.err_pc_write = err_q;

endmodule
